// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state encoding and
// parameter defaults used by the top and its wait timer.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int          MEM_TIMEOUT_DEFAULT = 15;
  localparam int          CNT_W_DEFAULT       = 4;
  localparam logic [31:0] INSTR_BYTES         = 32'd4;

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Consecutive wait-cycle counter for memory handshakes; flags when the count
// has reached the timeout limit.
module core_sequencer_wait_timer #(
  parameter int CNT_W       = core_sequencer_pkg::CNT_W_DEFAULT,
  parameter int MEM_TIMEOUT = core_sequencer_pkg::MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign expired = (cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, owns the PC,
// the memory/IR/regfile strobes and the retired-instruction counter.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int          CNT_W       = CNT_W_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic        i_reg_write,
  input  logic        i_pcsrc,
  input  logic [31:0] i_nextPC,
  input  logic        i_nop,
  output logic [31:0] o_pc,
  output logic        o_imem_req,
  output logic        o_ir_we,
  output logic        o_dmem_rd,
  output logic        o_dmem_wr,
  output logic        o_rf_we,
  output logic [2:0]  o_state,
  output logic        o_err,
  output logic [31:0] o_retired
);

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt_q, retired_q;
  logic [31:0] exec_target, retire_pc;
  logic        is_load_q, is_store_q;
  logic        retire, timer_en, expired;

  assign exec_target = i_pcsrc ? i_nextPC : pc_q + INSTR_BYTES;
  // Retiring straight out of EXEC happens on the same edge that would latch
  // pc_nxt_q, so the fresh target is forwarded.
  assign retire_pc   = (state == S_EXEC) ? exec_target : pc_nxt_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    timer_en  = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (i_imem_ready) state_nxt = S_DECODE;
        else if (expired) state_nxt = S_ERR;
        else              timer_en  = 1'b1;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (i_is_load && i_is_store)               state_nxt = S_ERR;
        else if (i_pcsrc && (i_nextPC[1:0] != 2'b00)) state_nxt = S_ERR;
        else if (i_nop)                            retire    = 1'b1;
        else if (i_is_load || i_is_store)          state_nxt = S_MEM;
        else if (i_reg_write)                      state_nxt = S_WB;
        else                                       retire    = 1'b1;
      end
      S_MEM: begin
        if (i_dmem_ready) begin
          if (is_load_q) state_nxt = S_WB;
          else           retire    = 1'b1;
        end else if (expired) begin
          state_nxt = S_ERR;
        end else begin
          timer_en = 1'b1;
        end
      end
      S_WB:    retire    = 1'b1;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
    if (retire) state_nxt = S_FETCH;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      pc_nxt_q   <= RESET_PC;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      if (state == S_EXEC) begin
        pc_nxt_q   <= exec_target;
        is_load_q  <= i_is_load;
        is_store_q <= i_is_store;
      end
      if (retire) begin
        pc_q      <= retire_pc;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  core_sequencer_wait_timer #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .clr     (!timer_en),
    .en      (timer_en),
    .expired (expired)
  );

  // Strobes are forced low for the whole time reset is held.
  logic active;
  assign active     = !i_rst;
  assign o_imem_req = active && (state == S_FETCH);
  assign o_ir_we    = active && (state == S_FETCH) && i_imem_ready;
  assign o_dmem_rd  = active && (state == S_MEM) && is_load_q;
  assign o_dmem_wr  = active && (state == S_MEM) && is_store_q;
  assign o_rf_we    = active && (state == S_WB);
  assign o_err      = (state == S_ERR);
  assign o_state    = state;
  assign o_pc       = pc_q;
  assign o_retired  = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: an instruction-level model expands
// each directed instruction into its expected per-cycle output trace.
module tb_core_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          MEM_TIMEOUT = 15;

  logic        clk, rst;
  logic        imem_ready, dmem_ready, is_load, is_store, reg_write, pcsrc, nop;
  logic [31:0] next_pc;
  logic [31:0] pc, retired;
  logic        imem_req, ir_we, dmem_rd, dmem_wr, rf_we, err;
  logic [2:0]  state;

  core_sequencer #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_imem_ready(imem_ready), .i_dmem_ready(dmem_ready),
    .i_is_load(is_load), .i_is_store(is_store), .i_reg_write(reg_write),
    .i_pcsrc(pcsrc), .i_nextPC(next_pc), .i_nop(nop),
    .o_pc(pc), .o_imem_req(imem_req), .o_ir_we(ir_we), .o_dmem_rd(dmem_rd),
    .o_dmem_wr(dmem_wr), .o_rf_we(rf_we), .o_state(state), .o_err(err),
    .o_retired(retired)
  );

  typedef enum {K_ALU, K_PLAIN, K_BRANCH, K_NOP, K_LOAD, K_STORE, K_BADLS, K_BADTGT} kind_e;

  typedef struct {
    logic        imem_ready, dmem_ready, is_load, is_store, reg_write, pcsrc, nop;
    logic [31:0] next_pc;
  } in_t;

  typedef struct {
    logic [2:0]  st;
    logic        imem_req, ir_we, rd, wr, rf_we, err;
    logic [31:0] pc, retired;
  } rec_t;

  rec_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rd_cycles = 0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_retired = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare process: one expected record per cycle, checked mid-cycle.
  always @(negedge clk) begin
    rec_t r;
    if (dmem_rd === 1'b1) rd_cycles++;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check("state",    32'(state),    32'(r.st));
      check("imem_req", 32'(imem_req), 32'(r.imem_req));
      check("ir_we",    32'(ir_we),    32'(r.ir_we));
      check("dmem_rd",  32'(dmem_rd),  32'(r.rd));
      check("dmem_wr",  32'(dmem_wr),  32'(r.wr));
      check("rf_we",    32'(rf_we),    32'(r.rf_we));
      check("err",      32'(err),      32'(r.err));
      check("pc",       pc,            r.pc);
      check("retired",  retired,       r.retired);
    end
  end

  function automatic rec_t base_rec(input logic [2:0] st);
    rec_t r;
    r.st = st; r.imem_req = 0; r.ir_we = 0; r.rd = 0; r.wr = 0; r.rf_we = 0;
    r.err = (st == 3'd7); r.pc = m_pc; r.retired = m_retired;
    return r;
  endfunction

  // Values that must be ignored wherever they are not the live input.
  function automatic in_t junk_in();
    in_t in;
    in.imem_ready = 1; in.dmem_ready = 1; in.is_load = 1; in.is_store = 1;
    in.reg_write = 1; in.pcsrc = 1; in.nop = 0; in.next_pc = 32'h0000_0013;
    return in;
  endfunction

  task automatic apply(input in_t in);
    imem_ready = in.imem_ready; dmem_ready = in.dmem_ready; is_load = in.is_load;
    is_store = in.is_store; reg_write = in.reg_write; pcsrc = in.pcsrc;
    nop = in.nop; next_pc = in.next_pc;
  endtask

  // Called at posedge+1: drive this cycle, queue its expectation, move on.
  task automatic cyc(input in_t in, input rec_t r);
    apply(in);
    exp_q.push_back(r);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(junk_in());
    #1;
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_dmem_rd",  32'(dmem_rd), 0);
    check("rst_state",    32'(state), 0);
    check("rst_pc",       pc, RESET_PC);
    check("rst_retired",  retired, 0);
    m_pc = RESET_PC; m_retired = 0;
    exp_q.push_back(base_rec(3'd0));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic err_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(junk_in(), base_rec(3'd7));
  endtask

  // Expands one instruction: fetch waits iw cycles, data access waits dw
  // cycles, abort_at >= 0 pulses reset during that MEM cycle.
  task automatic run_instr(input kind_e k, input int iw, input int dw,
                           input logic [31:0] tgt, input int abort_at);
    in_t  in;
    rec_t r;
    for (int c = 0; ; c++) begin
      in = junk_in(); in.imem_ready = (c == iw);
      r = base_rec(3'd0); r.imem_req = 1; r.ir_we = in.imem_ready;
      cyc(in, r);
      if (c == iw) break;
      if (c == MEM_TIMEOUT) return;
    end
    cyc(junk_in(), base_rec(3'd1));
    in = '{imem_ready: 1, dmem_ready: 1, is_load: 0, is_store: 0, reg_write: 0,
           pcsrc: 0, nop: 0, next_pc: 32'hFFFF_FFF0};
    case (k)
      K_ALU:    in.reg_write = 1;
      K_BRANCH: begin in.pcsrc = 1; in.next_pc = tgt; end
      K_NOP:    begin in.nop = 1; in.reg_write = 1; end
      K_LOAD:   begin in.is_load = 1; in.reg_write = 1; end
      K_STORE:  in.is_store = 1;
      K_BADLS:  begin in.is_load = 1; in.is_store = 1; in.reg_write = 1; end
      K_BADTGT: begin in.pcsrc = 1; in.next_pc = tgt; end
      default:  ;
    endcase
    cyc(in, base_rec(3'd2));
    if (k == K_BADLS || k == K_BADTGT) return;
    if (k == K_LOAD || k == K_STORE) begin
      for (int c = 0; ; c++) begin
        if (c == abort_at) begin
          check("mem_strobe_before_rst", 32'(k == K_LOAD ? dmem_rd : dmem_wr), 1);
          do_reset();
          return;
        end
        in = junk_in(); in.dmem_ready = (c == dw);
        r = base_rec(3'd3); r.rd = (k == K_LOAD); r.wr = (k == K_STORE);
        cyc(in, r);
        if (c == dw) break;
        if (c == MEM_TIMEOUT) return;
      end
    end
    if (k == K_ALU || k == K_LOAD) begin
      r = base_rec(3'd4); r.rf_we = 1;
      cyc(junk_in(), r);
    end
    m_pc = (k == K_BRANCH) ? tgt : m_pc + 32'd4;
    m_retired = m_retired + 32'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    apply(junk_in());
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // ALU op then branch
    run_instr(K_ALU, 0, 0, 0, -1);
    check("alu_pc", pc, 32'h4);
    check("alu_retired", retired, 32'd1);
    run_instr(K_BRANCH, 0, 0, 32'h40, -1);
    check("branch_pc", pc, 32'h40);

    // Load with 3 data wait cycles
    rd_cycles = 0;
    run_instr(K_LOAD, 2, 3, 0, -1);
    check("load_rd_cycles", 32'(rd_cycles), 4);
    check("load_pc", pc, 32'h44);

    run_instr(K_STORE, 0, 1, 0, -1);
    run_instr(K_NOP, 1, 0, 0, -1);
    run_instr(K_PLAIN, 0, 0, 0, -1);
    // Ready on the last permitted wait cycle still makes progress
    run_instr(K_ALU, 15, 0, 0, -1);
    run_instr(K_STORE, 0, 15, 0, -1);
    check("boundary_no_err", 32'(err), 0);
    check("boundary_pc", pc, 32'h58);
    check("boundary_retired", retired, 32'd8);

    // Fetch timeout
    run_instr(K_ALU, 16, 0, 0, -1);
    err_cycles(3);
    check("fetch_to_err", 32'(err), 1);
    check("fetch_to_state", 32'(state), 7);
    check("fetch_to_pc", pc, 32'h58);

    // Illegal load+store, misaligned target, data timeout
    do_reset();
    run_instr(K_ALU, 0, 0, 0, -1);
    run_instr(K_BADLS, 0, 0, 0, -1);
    err_cycles(2);
    check("badls_pc", pc, 32'h4);
    do_reset();
    run_instr(K_ALU, 0, 0, 0, -1);
    run_instr(K_BADTGT, 0, 0, 32'h42, -1);
    err_cycles(2);
    check("badtgt_err", 32'(err), 1);
    check("badtgt_pc", pc, 32'h4);
    do_reset();
    run_instr(K_LOAD, 0, 16, 0, -1);
    err_cycles(2);
    check("dmem_to_err", 32'(err), 1);

    // Reset pulse mid-MEM, then retire-counter wrap
    do_reset();
    run_instr(K_ALU, 0, 0, 0, -1);
    run_instr(K_LOAD, 0, 10, 0, 2);
    check("abort_pc", pc, RESET_PC);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    run_instr(K_ALU, 0, 0, 0, -1);
    check("wrap_retired", retired, 32'd0);
    check("wrap_pc", pc, 32'h4);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
